hazard_tracker: RTL and testbench

- Downstream consumer of the D-stage instruction controller.
- Takes each decoded D-stage instruction's register fields, destination (A3), Tuse and Tnew.
- Tracks destinations of in-flight instructions in the E, M and W pipeline slots.
- Generates the D-stage stall and the forwarding-mux selects for the D, E and M stages of the five-stage MIPS pipeline.

---
 rtl/hazard_tracker.sv | 101 ++++++++++
 tb/tb_hazard_tracker.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/hazard_tracker.sv
// Tracks E/M/W destinations behind the D stage and derives the D-stage stall plus D/E/M forwarding selects.
// Stall and selects are combinational on the tracked state; slots advance every edge, E takes a bubble while stalled.
module hazard_tracker #(
  parameter logic [1:0] TUSE_NONE = 2'd3,
  parameter logic [4:0] REG_ZERO  = 5'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [4:0] A3_D,
  input  logic [1:0] Tuse_rs_D,
  input  logic [1:0] Tuse_rt_D,
  input  logic [1:0] Tnew_D,
  output logic       stall,
  output logic [1:0] fwd_rs_D,
  output logic [1:0] fwd_rt_D,
  output logic [1:0] fwd_rs_E,
  output logic [1:0] fwd_rt_E,
  output logic       fwd_rt_M,
  output logic [4:0] A3_E,
  output logic [4:0] A3_M,
  output logic [4:0] A3_W,
  output logic [1:0] Tnew_E,
  output logic [1:0] Tnew_M
);

  logic [4:0] rs_E, rt_E, rt_M;
  logic       stall_rs, stall_rt;

  function automatic logic hit(input logic [4:0] r, input logic [4:0] a3);
    return (r != REG_ZERO) && (r == a3);
  endfunction

  function automatic logic needs_stall(input logic [4:0] r, input logic [1:0] tuse,
                                       input logic [4:0] a3_e, input logic [1:0] tnew_e,
                                       input logic [4:0] a3_m, input logic [1:0] tnew_m);
    return (tuse != TUSE_NONE) &&
           ((hit(r, a3_e) && (tnew_e > tuse)) || (hit(r, a3_m) && (tnew_m > tuse)));
  endfunction

  // Youngest matching producer decides; if it is not ready yet the select stays 00 and stall covers it.
  function automatic logic [1:0] sel_d(input logic [4:0] r,
                                       input logic [4:0] a3_e, input logic [1:0] tnew_e,
                                       input logic [4:0] a3_m, input logic [1:0] tnew_m,
                                       input logic [4:0] a3_w);
    if (hit(r, a3_e))      return (tnew_e == 2'd0) ? 2'b01 : 2'b00;
    else if (hit(r, a3_m)) return (tnew_m == 2'd0) ? 2'b10 : 2'b00;
    else if (hit(r, a3_w)) return 2'b11;
    else                   return 2'b00;
  endfunction

  function automatic logic [1:0] sel_e(input logic [4:0] r,
                                       input logic [4:0] a3_m, input logic [1:0] tnew_m,
                                       input logic [4:0] a3_w);
    if (hit(r, a3_m) && (tnew_m == 2'd0)) return 2'b10;
    else if (hit(r, a3_w))                return 2'b11;
    else                                  return 2'b00;
  endfunction

  always_comb begin
    stall_rs = needs_stall(rs_D, Tuse_rs_D, A3_E, Tnew_E, A3_M, Tnew_M);
    stall_rt = needs_stall(rt_D, Tuse_rt_D, A3_E, Tnew_E, A3_M, Tnew_M);
    stall    = stall_rs | stall_rt;
    fwd_rs_D = sel_d(rs_D, A3_E, Tnew_E, A3_M, Tnew_M, A3_W);
    fwd_rt_D = sel_d(rt_D, A3_E, Tnew_E, A3_M, Tnew_M, A3_W);
    fwd_rs_E = sel_e(rs_E, A3_M, Tnew_M, A3_W);
    fwd_rt_E = sel_e(rt_E, A3_M, Tnew_M, A3_W);
    fwd_rt_M = hit(rt_M, A3_W);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs_E   <= 5'd0;
      rt_E   <= 5'd0;
      A3_E   <= 5'd0;
      Tnew_E <= 2'd0;
      rt_M   <= 5'd0;
      A3_M   <= 5'd0;
      Tnew_M <= 2'd0;
      A3_W   <= 5'd0;
    end else begin
      if (stall) begin
        rs_E   <= 5'd0;
        rt_E   <= 5'd0;
        A3_E   <= 5'd0;
        Tnew_E <= 2'd0;
      end else begin
        rs_E   <= rs_D;
        rt_E   <= rt_D;
        A3_E   <= A3_D;
        Tnew_E <= Tnew_D;
      end
      rt_M   <= rt_E;
      A3_M   <= A3_E;
      Tnew_M <= (Tnew_E == 2'd0) ? 2'd0 : Tnew_E - 2'd1;
      A3_W   <= A3_M;
    end
  end

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed-vector bench for hazard_tracker with hand-computed expectations.
module tb_hazard_tracker;

  localparam logic [1:0] NONE = 2'd3;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_D, rt_D, A3_D;
  logic [1:0] Tuse_rs_D, Tuse_rt_D, Tnew_D;
  logic       stall;
  logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
  logic       fwd_rt_M;
  logic [4:0] A3_E, A3_M, A3_W;
  logic [1:0] Tnew_E, Tnew_M;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_tracker dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .A3_D(A3_D),
    .Tuse_rs_D(Tuse_rs_D), .Tuse_rt_D(Tuse_rt_D), .Tnew_D(Tnew_D),
    .stall(stall),
    .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
    .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E), .fwd_rt_M(fwd_rt_M),
    .A3_E(A3_E), .A3_M(A3_M), .A3_W(A3_W),
    .Tnew_E(Tnew_E), .Tnew_M(Tnew_M)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_d(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] a3,
                         input logic [1:0] tus, input logic [1:0] tut, input logic [1:0] tnew);
    rs_D = rs; rt_D = rt; A3_D = a3;
    Tuse_rs_D = tus; Tuse_rt_D = tut; Tnew_D = tnew;
    #1;
  endtask

  task automatic nop();
    drive_d(5'd0, 5'd0, 5'd0, NONE, NONE, 2'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Asynchronous reset pulse placed between clock edges; state must clear at once.
  task automatic rst_pulse(input string tag);
    reset = 1'b0;
    #1;
    check({tag, "_stall"}, {31'd0, stall}, 32'd0);
    check({tag, "_a3"}, {17'd0, A3_E, A3_M, A3_W}, 32'd0);
    #1;
    reset = 1'b1;
  endtask

  task automatic store_case(input logic [4:0] rt, input logic exp);
    rst_pulse("st_rst");
    drive_d(5'd29, 5'd0, 5'd9, 2'd1, NONE, 2'd2);   // lw $9
    tick();
    drive_d(5'd29, rt, 5'd0, 2'd1, 2'd2, 2'd0);     // sw rt
    check("st_nostall", {31'd0, stall}, 32'd0);
    tick();
    nop();
    check("st_fwd_rt_E", {30'd0, fwd_rt_E}, 32'd0);
    tick();
    check("st_A3_W", {27'd0, A3_W}, 32'd9);
    check("st_fwd_rt_M", {31'd0, fwd_rt_M}, {31'd0, exp});
  endtask

  initial begin
    // Reset held with arbitrary D inputs
    reset = 1'b0;
    drive_d(5'd8, 5'd8, 5'd8, 2'd0, 2'd0, 2'd2);
    tick();
    tick();
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_fwd", {23'd0, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M}, 32'd0);
    check("rst_a3", {17'd0, A3_E, A3_M, A3_W}, 32'd0);
    check("rst_tnew", {28'd0, Tnew_E, Tnew_M}, 32'd0);
    reset = 1'b1;
    drive_d(5'd29, 5'd8, 5'd8, 2'd1, NONE, 2'd2);    // lw $8
    tick();
    check("lw_A3_E", {27'd0, A3_E}, 32'd8);
    check("lw_Tnew_E", {30'd0, Tnew_E}, 32'd2);

    // Load-use into an ALU op
    drive_d(5'd8, 5'd9, 5'd10, 2'd1, 2'd1, 2'd1);    // addu $10,$8,$9
    check("alu_stall0", {31'd0, stall}, 32'd1);
    check("alu_fwd_blocked", {30'd0, fwd_rs_D}, 32'd0);
    tick();
    check("alu_bubble", {27'd0, A3_E}, 32'd0);
    check("alu_M", {25'd0, A3_M, Tnew_M}, {25'd0, 5'd8, 2'd1});
    check("alu_stall1", {31'd0, stall}, 32'd0);
    tick();
    nop();
    check("alu_E", {25'd0, A3_E, Tnew_E}, {25'd0, 5'd10, 2'd1});
    check("alu_fwd_rs_E", {30'd0, fwd_rs_E}, 32'd3);
    drive_d(5'd10, 5'd0, 5'd0, 2'd0, NONE, 2'd0);    // branch on $10 behind ALU
    check("alu_br_stall", {31'd0, stall}, 32'd1);
    rst_pulse("mid_rst");

    // Load-use into a branch: two bubbles
    drive_d(5'd29, 5'd0, 5'd8, 2'd1, NONE, 2'd2);
    tick();
    drive_d(5'd8, 5'd0, 5'd0, 2'd0, 2'd0, 2'd0);     // beq $8,$0
    check("beq_stall0", {31'd0, stall}, 32'd1);
    tick();
    check("beq_stall1", {31'd0, stall}, 32'd1);
    check("beq_fwd1", {30'd0, fwd_rs_D}, 32'd0);
    tick();
    check("beq_stall2", {31'd0, stall}, 32'd0);
    check("beq_bubbles", {22'd0, A3_E, A3_M}, 32'd0);
    check("beq_fwd_W", {30'd0, fwd_rs_D}, 32'd3);
    check("beq_fwd_rt_zero", {30'd0, fwd_rt_D}, 32'd0);

    // Forwarding priority E > M > W
    rst_pulse("pri_rst");
    drive_d(5'd0, 5'd0, 5'd31, NONE, NONE, 2'd1);
    tick();
    drive_d(5'd0, 5'd0, 5'd31, NONE, NONE, 2'd1);    // ori $31
    tick();
    drive_d(5'd0, 5'd0, 5'd31, NONE, NONE, 2'd0);    // jal
    tick();
    drive_d(5'd31, 5'd0, 5'd0, 2'd0, NONE, 2'd0);    // jr $31
    check("pri_stall", {31'd0, stall}, 32'd0);
    check("pri_fwd_E", {30'd0, fwd_rs_D}, 32'd1);
    check("pri_Tnew_M", {30'd0, Tnew_M}, 32'd0);
    check("pri_A3_W", {27'd0, A3_W}, 32'd31);
    tick();
    check("pri_fwd_M", {30'd0, fwd_rs_D}, 32'd2);
    check("pri_fwd_rs_E", {30'd0, fwd_rs_E}, 32'd2);
    check("pri_fwd_rt_E", {30'd0, fwd_rt_E}, 32'd0);
    tick();
    check("pri_fwd_W", {30'd0, fwd_rs_D}, 32'd3);
    check("pri_fwd_rs_E_W", {30'd0, fwd_rs_E}, 32'd3);

    // Register zero never matches
    rst_pulse("zero_rst");
    drive_d(5'd29, 5'd0, 5'd0, 2'd1, NONE, 2'd2);
    tick();
    drive_d(5'd0, 5'd0, 5'd10, 2'd1, 2'd1, 2'd1);
    check("zero_stall", {31'd0, stall}, 32'd0);
    check("zero_fwd", {30'd0, fwd_rs_D}, 32'd0);

    // Store data forwarded from W
    store_case(5'd9, 1'b1);
    store_case(5'd10, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
